// File: rtl/chunk_serializer_if.sv
// Chunk-in / byte-out stream bundle for chunk_serializer.
// slave = serializer side, master = producer/consumer side.
interface chunk_serializer_if #(
  parameter int WRITE_WIDTH    = 8,
  parameter int READ_WIDTH_MUL = 27
);
  localparam int LEN_W = $clog2(READ_WIDTH_MUL + 1);

  logic [READ_WIDTH_MUL*WRITE_WIDTH-1:0] in_data;
  logic [LEN_W-1:0]                      in_len;
  logic                                  in_last;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [WRITE_WIDTH-1:0]                out_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic                                  out_last;

  modport master (
    output in_data, in_len, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_len, in_last, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/chunk_serializer.sv
// Wide-to-narrow converter: one chunk in, its elements out LSB first.
// A one-chunk pending slot keeps the byte stream bubble-free.
module chunk_serializer #(
  parameter int WRITE_WIDTH    = 8,
  parameter int READ_WIDTH_MUL = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  chunk_serializer_if.slave   bus,
  output logic                busy
);
  localparam int DW = WRITE_WIDTH * READ_WIDTH_MUL;
  localparam int LW = $clog2(READ_WIDTH_MUL + 1);
  localparam logic [LW-1:0] MAX_LEN = LW'(READ_WIDTH_MUL);
  localparam logic [LW-1:0] ONE     = LW'(1);

  logic [DW-1:0] r_cur_sr;
  logic [LW-1:0] r_cur_rem;
  logic          r_cur_last;
  logic          r_cur_valid;
  logic [DW-1:0] r_pend_data;
  logic [LW-1:0] r_pend_len;
  logic          r_pend_last;
  logic          r_pend_valid;

  logic [LW-1:0] w_len;
  logic          w_accept;
  logic          w_out_fire;
  logic          w_cur_done;
  logic          w_cur_free;

  // Oversized lengths clamp to a full chunk.
  assign w_len = (bus.in_len > MAX_LEN) ? MAX_LEN : bus.in_len;

  assign bus.in_ready  = !r_pend_valid && !flush;
  assign w_accept      = bus.in_valid && bus.in_ready && (w_len != '0);
  assign w_out_fire    = r_cur_valid && bus.out_ready;
  assign w_cur_done    = w_out_fire && (r_cur_rem == ONE);
  assign w_cur_free    = !r_cur_valid || w_cur_done;

  assign bus.out_valid = r_cur_valid;
  assign bus.out_data  = r_cur_sr[WRITE_WIDTH-1:0];
  assign bus.out_last  = r_cur_last && (r_cur_rem == ONE);
  assign busy          = r_cur_valid || r_pend_valid;

  // Current chunk: refill from pending first, then from input, else shift out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_sr    <= '0;
      r_cur_rem   <= '0;
      r_cur_last  <= 1'b0;
      r_cur_valid <= 1'b0;
    end else if (flush) begin
      r_cur_rem   <= '0;
      r_cur_last  <= 1'b0;
      r_cur_valid <= 1'b0;
    end else if (w_cur_free) begin
      if (r_pend_valid) begin
        r_cur_sr    <= r_pend_data;
        r_cur_rem   <= r_pend_len;
        r_cur_last  <= r_pend_last;
        r_cur_valid <= 1'b1;
      end else if (w_accept) begin
        r_cur_sr    <= bus.in_data;
        r_cur_rem   <= w_len;
        r_cur_last  <= bus.in_last;
        r_cur_valid <= 1'b1;
      end else begin
        r_cur_rem   <= '0;
        r_cur_last  <= 1'b0;
        r_cur_valid <= 1'b0;
      end
    end else if (w_out_fire) begin
      r_cur_sr  <= r_cur_sr >> WRITE_WIDTH;
      r_cur_rem <= r_cur_rem - ONE;
    end
  end

  // Pending slot: filled only while the current chunk is still busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_data  <= '0;
      r_pend_len   <= '0;
      r_pend_last  <= 1'b0;
      r_pend_valid <= 1'b0;
    end else if (flush) begin
      r_pend_valid <= 1'b0;
    end else if (w_cur_free && r_pend_valid) begin
      r_pend_valid <= 1'b0;
    end else if (w_accept && !w_cur_free) begin
      r_pend_data  <= bus.in_data;
      r_pend_len   <= w_len;
      r_pend_last  <= bus.in_last;
      r_pend_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_chunk_serializer.sv
// Self-checking bench for chunk_serializer.
// Reference model: queue of expected bytes plus per-chunk byte counts.
module tb_chunk_serializer;
  localparam int W  = 8;
  localparam int M  = 27;
  localparam int DW = W * M;
  localparam int LW = $clog2(M + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  chunk_serializer_if #(.WRITE_WIDTH(W), .READ_WIDTH_MUL(M)) bus();

  chunk_serializer #(.WRITE_WIDTH(W), .READ_WIDTH_MUL(M)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [8:0]    exp_q[$];
  int            held_q[$];
  logic [DW-1:0] ld_q[$];
  int            ll_q[$];
  bit            lt_q[$];
  bit            acc;

  function automatic logic [DW-1:0] ramp(input int base);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < M; k++) r[k*W +: W] = W'(base + k);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < M; k++) r[k*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic void push_chunk(input logic [DW-1:0] d, input int len,
                                     input bit last);
    int l;
    l = (len > M) ? M : len;
    if (l == 0) return;
    for (int k = 0; k < l; k++)
      exp_q.push_back({last && (k == l - 1), d[k*W +: W]});
    held_q.push_back(l);
  endfunction

  function automatic void pop_byte();
    void'(exp_q.pop_front());
    held_q[0] = held_q[0] - 1;
    if (held_q[0] == 0) void'(held_q.pop_front());
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    held_q.delete();
    ld_q.delete();
    ll_q.delete();
    lt_q.delete();
    acc = 1'b0;
  endfunction

  function automatic void add_chunk(input logic [DW-1:0] d, input int len,
                                    input bit last);
    ld_q.push_back(d);
    ll_q.push_back(len);
    lt_q.push_back(last);
  endfunction

  task automatic drive();
    if (acc) bus.in_valid = 1'b0;
    acc = 1'b0;
    if (!bus.in_valid && ld_q.size() != 0) begin
      bus.in_data  = ld_q.pop_front();
      bus.in_len   = LW'(ll_q.pop_front());
      bus.in_last  = lt_q.pop_front();
      bus.in_valid = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 8'h00) begin
      failures++; $display("FAIL rst_out_data: got %h want 00", bus.out_data);
    end
    checks++;
    if (bus.out_last !== 1'b0) begin
      failures++; $display("FAIL rst_out_last: got %b want 0", bus.out_last);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL post_rst_idle: got %b want 010",
               {bus.out_valid, bus.in_ready, busy});
    end
  endtask

  task automatic test_single();
    model_clear();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_data  = ramp(1);
    bus.in_len   = LW'(27);
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL single_accept: in_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_last, bus.out_data} !==
          {1'b1, (k == 26), W'(k + 1)}) begin
        failures++;
        $display("FAIL single_byte%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 k, bus.out_valid, bus.out_last, bus.out_data, (k == 26), W'(k + 1));
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++; $display("FAIL single_in_ready%0d: got %b want 1", k, bus.in_ready);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_done: got valid/busy %b want 00", {bus.out_valid, busy});
    end
  endtask

  task automatic test_back_to_back();
    int first, last, nvalid;
    first = -1; last = -1; nvalid = 0;
    model_clear();
    bus.out_ready = 1'b1;
    add_chunk(ramp(8'h10), 27, 1'b0);
    add_chunk(ramp(8'h80), 5, 1'b0);
    add_chunk(ramp(8'hC0), 3, 1'b1);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      checks++;
      if (bus.in_ready !== (held_q.size() < 2)) begin
        failures++;
        $display("FAIL b2b_in_ready c%0d: got %b want %b", cyc, bus.in_ready,
                 (held_q.size() < 2));
      end
      checks++;
      if (bus.out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL b2b_out_valid c%0d: got %b want %b", cyc, bus.out_valid,
                 (exp_q.size() != 0));
      end
      if (bus.out_valid === 1'b1 && exp_q.size() != 0) begin
        checks++;
        if ({bus.out_last, bus.out_data} !== exp_q[0]) begin
          failures++;
          $display("FAIL b2b_data c%0d: got %h want %h", cyc,
                   {bus.out_last, bus.out_data}, exp_q[0]);
        end
      end
      if (bus.out_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        if (bus.in_len == LW'(3)) begin
          checks++;
          if (exp_q.size() != 5) begin
            failures++;
            $display("FAIL b2b_c_accept: bytes left got %0d want 5", exp_q.size());
          end
        end
        push_chunk(bus.in_data, int'(bus.in_len), bus.in_last);
        acc = 1'b1;
      end
      if (bus.out_valid === 1'b1 && exp_q.size() != 0) pop_byte();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (nvalid != 35 || last - first + 1 != 35) begin
      failures++;
      $display("FAIL b2b_run: valid cycles got %0d span %0d want 35", nvalid,
               last - first + 1);
    end
  endtask

  task automatic test_empty_chunk();
    int nbytes;
    bit last_seen;
    nbytes = 0; last_seen = 1'b0;
    model_clear();
    bus.out_ready = 1'b1;
    add_chunk(ramp(8'h21), 2, 1'b0);
    add_chunk(ramp(8'h55), 0, 1'b1);
    add_chunk(ramp(8'h31), 2, 1'b0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL empty_out_valid c%0d: got %b want %b", cyc, bus.out_valid,
                 (exp_q.size() != 0));
      end
      if (bus.out_valid === 1'b1) begin
        nbytes++;
        if (bus.out_last !== 1'b0) last_seen = 1'b1;
        if (exp_q.size() != 0) begin
          checks++;
          if ({bus.out_last, bus.out_data} !== exp_q[0]) begin
            failures++;
            $display("FAIL empty_data c%0d: got %h want %h", cyc,
                     {bus.out_last, bus.out_data}, exp_q[0]);
          end
          pop_byte();
        end
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        push_chunk(bus.in_data, int'(bus.in_len), bus.in_last);
        acc = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (nbytes != 4 || last_seen) begin
      failures++;
      $display("FAIL empty_total: bytes %0d last_seen %b want 4 and 0", nbytes,
               last_seen);
    end
  endtask

  task automatic test_random_stall();
    bit prev_stall;
    logic [8:0] prev_word;
    prev_stall = 1'b0; prev_word = '0;
    model_clear();
    for (int i = 0; i < 14; i++)
      add_chunk(rand_data(), $urandom_range(0, 31), 1'($urandom));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ld_q.size() == 0 && !bus.in_valid && exp_q.size() == 0) break;
      @(posedge clk); #1;
      drive();
      bus.out_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== (held_q.size() < 2)) begin
        failures++;
        $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, bus.in_ready,
                 (held_q.size() < 2));
      end
      checks++;
      if (busy !== (held_q.size() != 0)) begin
        failures++;
        $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, (held_q.size() != 0));
      end
      checks++;
      if (bus.out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL rnd_out_valid c%0d: got %b want %b", cyc, bus.out_valid,
                 (exp_q.size() != 0));
      end
      if (bus.out_valid === 1'b1 && exp_q.size() != 0) begin
        checks++;
        if ({bus.out_last, bus.out_data} !== exp_q[0]) begin
          failures++;
          $display("FAIL rnd_data c%0d: got %h want %h", cyc,
                   {bus.out_last, bus.out_data}, exp_q[0]);
        end
      end
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_last, bus.out_data} !== prev_word) begin
          failures++;
          $display("FAIL rnd_stable c%0d: got v=%b %h want v=1 %h", cyc,
                   bus.out_valid, {bus.out_last, bus.out_data}, prev_word);
        end
      end
      prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
      prev_word  = {bus.out_last, bus.out_data};
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        push_chunk(bus.in_data, int'(bus.in_len), bus.in_last);
        acc = 1'b1;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready && exp_q.size() != 0) pop_byte();
    end
    @(posedge clk); #1;
    drive();
    bus.out_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0 || ld_q.size() != 0) begin
      failures++;
      $display("FAIL rnd_timeout: bytes left %0d chunks left %0d want 0", exp_q.size(),
               ld_q.size());
    end
  endtask

  task automatic test_flush();
    int sent;
    sent = 0;
    model_clear();
    bus.out_ready = 1'b1;
    add_chunk(ramp(1), 27, 1'b1);
    add_chunk(ramp(8'h60), 27, 1'b0);
    for (int cyc = 0; cyc < 40 && sent < 10; cyc++) begin
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      if (bus.out_valid === 1'b1 && exp_q.size() != 0) begin
        checks++;
        if ({bus.out_last, bus.out_data} !== exp_q[0]) begin
          failures++;
          $display("FAIL flush_pre_data: got %h want %h",
                   {bus.out_last, bus.out_data}, exp_q[0]);
        end
        pop_byte();
        sent++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        push_chunk(bus.in_data, int'(bus.in_len), bus.in_last);
        acc = 1'b1;
      end
    end
    @(posedge clk); #1;
    flush        = 1'b1;
    bus.in_data  = ramp(8'hE0);
    bus.in_len   = LW'(4);
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, busy, held_q.size() == 2} !== 4'b0111) begin
      failures++;
      $display("FAIL flush_cycle: rdy/val/busy/pend got %b want 0111",
               {bus.in_ready, bus.out_valid, busy, held_q.size() == 2});
    end
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, busy, bus.in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL flush_after: val/busy/rdy got %b want 001",
               {bus.out_valid, busy, bus.in_ready});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++; $display("FAIL flush_leak%0d: out_valid got %b want 0", i, bus.out_valid);
      end
    end
    model_clear();
  endtask

  task automatic test_async_reset();
    model_clear();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_data  = ramp(1);
    bus.in_len   = LW'(27);
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_data, busy, bus.in_ready} !==
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL arst_outputs: v/l/d/busy/rdy got %b/%b/%h/%b/%b want 0/0/00/0/1",
               bus.out_valid, bus.out_last, bus.out_data, busy, bus.in_ready);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.in_data  = ramp(8'h90);
    bus.in_len   = LW'(4);
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL arst_idle: val/rdy got %b want 01", {bus.out_valid, bus.in_ready});
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_last, bus.out_data} !==
          {1'b1, (k == 3), W'(8'h90 + k)}) begin
        failures++;
        $display("FAIL arst_byte%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", k,
                 bus.out_valid, bus.out_last, bus.out_data, (k == 3), W'(8'h90 + k));
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL arst_end: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_len    = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    acc           = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_empty_chunk();
    test_random_stall();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
